hop_sprite: RTL
===============

# hop_sprite

Parametrised hopping-sprite position controller: the next generation of the player-movement block in the VGA game pipeline. It turns active-low direction buttons into fixed-distance hops animated in HOP_STEP-pixel increments per animation strobe. It adds what the previous block lacked: screen-edge blocking, a one-deep queued move, platform drift, a timed death/respawn sequence and a lives counter. Its outputs feed the sprite renderer and collision logic, with the same edge-coordinate convention as the existing obstacle blocks.

## Interface
- H_WIDTH, 11, half sprite width (px)
- H_HEIGHT, 11, half sprite height (px)
- IX, 320, spawn centre x
- IY, 469, spawn centre y
- D_WIDTH, 640, display width
- D_HEIGHT, 480, display height
- HOP_DIS, 72, pixels per hop; must be a multiple of HOP_STEP
- HOP_STEP, 4, pixels moved per animation tick
- DRIFT_W, 4, width of signed drift input
- DEAD_FRAMES, 30, ticks spent in death sequence
- LIVES, 3, lives at reset (1..7)
- i_clk  in  1  base clock
- i_rst_n  in  1  reset, asynchronous assert, active-low (already decided)
- i_ani_stb  in  1  animation strobe, one i_clk pulse per frame
- i_animate  in  1  tick enable; tick = i_ani_stb & i_animate
- i_up_btn, i_down_btn, i_left_btn, i_right_btn  in  1 each  buttons, active-low
- i_dead  in  1  collision kill request
- i_drift  in  DRIFT_W  signed x drift per tick (riding platform)
- o_x1, o_x2, o_y1, o_y2  out  12 each  sprite left/right/top/bottom edges
- o_hopping  out  1  high in HOP
- o_dying  out  1  high in DEAD
- o_hop_done  out  1  one-i_clk pulse when a hop completes
- o_blocked  out  1  one-i_clk pulse when a hop is rejected
- o_lives  out  3  remaining lives
- o_game_over  out  1  lives exhausted

## Operation
- State machine: IDLE, HOP, DEAD, OVER. All state, position and counter updates happen only on a tick.
- Request sampling: a button is pressed when low. If several are pressed together, priority is up > down > left > right.
- IDLE tick, start of a hop:
  - The move is taken from the queue if the queue is valid, otherwise from the buttons.
  - Target is centre ± HOP_DIS on the relevant axis.
  - Legal target (x−H_WIDTH ≥ 0, x+H_WIDTH ≤ D_WIDTH−1, y−H_HEIGHT ≥ 0, y+H_HEIGHT ≤ D_HEIGHT−1): latch direction, clear distance, go to HOP.
  - Illegal target: pulse o_blocked and stay in IDLE.
  - The queue is cleared in either case.
- HOP tick:
  - Centre moves HOP_STEP in the latched direction and distance += HOP_STEP.
  - When distance reaches HOP_DIS on this tick: go to IDLE and pulse o_hop_done.
  - A hop takes HOP_DIS/HOP_STEP ticks (18 at defaults).
- Queue: holds one entry. The first request sampled on a HOP tick while the queue is empty is stored. Later requests are dropped until the queue is consumed.
- Drift:
  - In IDLE and HOP, x += sign-extended i_drift on every tick.
  - The result is clamped to [H_WIDTH, D_WIDTH−1−H_WIDTH].
  - Drift and hop step add on the same tick.
  - There is no drift in DEAD or OVER.
- Death:
  - i_dead on a tick in IDLE or HOP: go to DEAD, load the frame counter with DEAD_FRAMES, clear the queue, decrement lives. Position freezes.
  - i_dead has priority over hop completion on the same tick.
  - While in DEAD, i_dead is ignored.
- DEAD exit: when the counter reaches 0, centre returns to (IX,IY). Next state is IDLE if lives > 0, otherwise OVER.
- OVER: o_game_over = 1, position frozen at spawn. Only reset leaves this state.
- Reset (asynchronous, any state, including mid-hop): IDLE, centre = (IX,IY), distance 0, queue empty, lives = LIVES, all pulses 0.

## Timing
- Position registers update on the i_clk edge at which the tick is high. o_x1..o_y2 are combinational from the centre registers (centre ± half-size, 12-bit), so they change in the same cycle as the centre.
- o_hop_done and o_blocked are high for exactly one i_clk, in the cycle after the qualifying tick.
- A queued hop starts on the first IDLE tick after completion, leaving one tick of rest between hops.
- Reset values: o_x1=309, o_x2=331, o_y1=458, o_y2=480, o_hopping=0, o_dying=0, o_lives=LIVES, o_game_over=0.
- Arithmetic: 12-bit unsigned centres. Bounds checks use 13-bit signed intermediates so that underflow cannot wrap. The distance counter is $clog2(HOP_DIS+1) bits wide.

## Structure
- Package hop_pkg holds:
  - the state enum (IDLE/HOP/DEAD/OVER);
  - the direction enum (UP/DOWN/LEFT/RIGHT);
  - the priority-encode function;
  - the legal-target check function.
- One sub-module: hop_req_queue, the one-entry direction queue with valid flag, push and pop.

## Test plan
- Reset, hold up low for one tick: 18 ticks later centre y = 397, o_hop_done pulses once, o_hopping falls.
- At spawn, press down: o_blocked pulses, y stays 469, state stays IDLE.
- Press up, press left at tick 5 of the hop, press right at tick 6: after the up hop completes, one idle tick, then a left hop to x = 248. The right press is dropped.
- IDLE with i_drift = −3 at x = 14 for 2 ticks: x = 11 and holds (clamped).
- i_dead at hop tick 9: position freezes, o_dying high for 30 ticks, then centre = (320,469) and o_lives = 2.
- Three deaths: o_game_over = 1 and buttons are ignored. Assert i_rst_n low mid-DEAD: IDLE immediately, o_lives = 3.

Source files
------------

// File: rtl/hop_pkg.sv
// ---------------------------------------------------------------------------
// hop_pkg
// Shared types and helpers for the hopping-sprite position controller.
//   state_t      : controller state (IDLE / HOP / DEAD / OVER)
//   dir_t        : hop direction (UP / DOWN / LEFT / RIGHT)
//   req_t        : a sampled move request (valid flag + direction)
//   prio_encode  : turns the active-high "pressed" vector into one request,
//                  priority up > down > left > right
//   target_legal : true when a sprite centred on (tx,ty) lies fully on screen
// ---------------------------------------------------------------------------
package hop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOP  = 2'd1,
    DEAD = 2'd2,
    OVER = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } req_t;

  // Bit order of pressed: [0]=up, [1]=down, [2]=left, [3]=right.
  function automatic req_t prio_encode(input logic [3:0] pressed);
    req_t r;
    r.valid = |pressed;
    if (pressed[0])      r.dir = UP;
    else if (pressed[1]) r.dir = DOWN;
    else if (pressed[2]) r.dir = LEFT;
    else                 r.dir = RIGHT;
    return r;
  endfunction

  // Works on signed values so a target left of / above the origin is seen as
  // negative rather than wrapping to a large unsigned coordinate.
  function automatic logic target_legal(input logic signed [12:0] tx,
                                        input logic signed [12:0] ty,
                                        input int hw,
                                        input int hh,
                                        input int dw,
                                        input int dh);
    int x;
    int y;
    x = int'(tx);
    y = int'(ty);
    return (x - hw >= 0) && (x + hw <= dw - 1) &&
           (y - hh >= 0) && (y + hh <= dh - 1);
  endfunction

endpackage

// File: rtl/hop_sprite_if.sv
// ---------------------------------------------------------------------------
// hop_sprite_if
// Bundles the controller's frame/button/collision inputs and its sprite-edge
// and status outputs.
//   master : the game logic side (drives i_*, reads o_*)
//   slave  : the hop_sprite controller (reads i_*, drives o_*)
// Inputs : i_ani_stb, i_animate, i_up/down/left/right_btn (active-low),
//          i_dead, i_drift (signed, DRIFT_W bits)
// Outputs: o_x1/o_x2/o_y1/o_y2 (edges), o_hopping, o_dying, o_hop_done,
//          o_blocked, o_lives, o_game_over
// ---------------------------------------------------------------------------
interface hop_sprite_if #(
  parameter int DRIFT_W = 4
);
  logic                      i_ani_stb;
  logic                      i_animate;
  logic                      i_up_btn;
  logic                      i_down_btn;
  logic                      i_left_btn;
  logic                      i_right_btn;
  logic                      i_dead;
  logic signed [DRIFT_W-1:0] i_drift;

  logic [11:0]               o_x1;
  logic [11:0]               o_x2;
  logic [11:0]               o_y1;
  logic [11:0]               o_y2;
  logic                      o_hopping;
  logic                      o_dying;
  logic                      o_hop_done;
  logic                      o_blocked;
  logic [2:0]                o_lives;
  logic                      o_game_over;

  modport master (
    output i_ani_stb, i_animate, i_up_btn, i_down_btn, i_left_btn, i_right_btn,
           i_dead, i_drift,
    input  o_x1, o_x2, o_y1, o_y2, o_hopping, o_dying, o_hop_done, o_blocked,
           o_lives, o_game_over
  );

  modport slave (
    input  i_ani_stb, i_animate, i_up_btn, i_down_btn, i_left_btn, i_right_btn,
           i_dead, i_drift,
    output o_x1, o_x2, o_y1, o_y2, o_hopping, o_dying, o_hop_done, o_blocked,
           o_lives, o_game_over
  );
endinterface

// File: rtl/hop_req_queue.sv
// ---------------------------------------------------------------------------
// hop_req_queue
// One-entry move queue. A push is accepted only while the entry is empty, so
// the first request wins and later ones are dropped. Clear and pop both
// empty the entry and take precedence over a push on the same cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : discard the entry (death)
//   i_pop          : entry consumed by the controller
//   i_push         : store i_push_dir if the entry is empty
//   o_valid, o_dir : current entry
// ---------------------------------------------------------------------------
module hop_req_queue
  import hop_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_pop,
  input  logic i_push,
  input  dir_t i_push_dir,
  output logic o_valid,
  output dir_t o_dir
);

  logic valid_reg, valid_next;
  dir_t dir_reg, dir_next;

  always_comb begin
    valid_next = valid_reg;
    dir_next   = dir_reg;
    if (i_clr || i_pop) begin
      valid_next = 1'b0;
    end else if (i_push && !valid_reg) begin
      valid_next = 1'b1;
      dir_next   = i_push_dir;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_reg <= 1'b0;
      dir_reg   <= UP;
    end else begin
      valid_reg <= valid_next;
      dir_reg   <= dir_next;
    end
  end

  assign o_valid = valid_reg;
  assign o_dir   = dir_reg;

endmodule

// File: rtl/hop_sprite.sv
// ---------------------------------------------------------------------------
// hop_sprite
// Hopping-sprite position controller. Buttons start fixed-distance hops that
// are animated HOP_STEP pixels per tick (tick = i_ani_stb & i_animate). Hops
// that would leave the screen are rejected, one further request can be
// queued during a hop, a signed platform drift is added to x, and a collision
// runs a timed death sequence that costs a life and respawns the sprite.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   bus     : hop_sprite_if.slave, inputs/outputs listed in the interface
// Edge outputs are combinational from the centre registers (centre +/- half
// size); o_hop_done / o_blocked are single-cycle registered pulses.
// ---------------------------------------------------------------------------
module hop_sprite
  import hop_pkg::*;
#(
  parameter int H_WIDTH     = 11,
  parameter int H_HEIGHT    = 11,
  parameter int IX          = 320,
  parameter int IY          = 469,
  parameter int D_WIDTH     = 640,
  parameter int D_HEIGHT    = 480,
  parameter int HOP_DIS     = 72,
  parameter int HOP_STEP    = 4,
  parameter int DRIFT_W     = 4,
  parameter int DEAD_FRAMES = 30,
  parameter int LIVES       = 3
) (
  input logic         i_clk,
  input logic         i_rst_n,
  hop_sprite_if.slave bus
);

  localparam int DIST_W = $clog2(HOP_DIS + 1);
  localparam int CNT_W  = $clog2(DEAD_FRAMES + 1);

  localparam logic signed [12:0] HOP_DIS_S = 13'(HOP_DIS);
  localparam logic signed [12:0] STEP_S    = 13'(HOP_STEP);
  localparam logic signed [12:0] X_MIN     = 13'(H_WIDTH);
  localparam logic signed [12:0] X_MAX     = 13'(D_WIDTH - 1 - H_WIDTH);

  state_t             state_reg, state_next;
  logic [11:0]        x_reg, x_next;
  logic [11:0]        y_reg, y_next;
  logic [DIST_W-1:0]  dist_reg, dist_next, dist_inc;
  dir_t               dir_reg, dir_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2:0]         lives_reg, lives_next;
  logic               hop_done_reg, hop_done_next;
  logic               blocked_reg, blocked_next;

  logic               tick;
  logic [3:0]         btn_n;
  logic [3:0]         pressed;
  req_t               btn_req;
  req_t               mv_req;
  logic               q_valid;
  dir_t               q_dir;
  logic               q_push, q_pop, q_clr;

  logic signed [12:0] cx, cy, tx, ty, sx, drift_s;
  logic               mv_legal;
  logic [11:0]        x_idle, x_hop, y_hop;

  assign tick = bus.i_ani_stb & bus.i_animate;

  // Buttons are active-low; build an active-high pressed vector.
  assign btn_n = {bus.i_right_btn, bus.i_left_btn, bus.i_down_btn, bus.i_up_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      assign pressed[gi] = ~btn_n[gi];
    end
  endgenerate

  assign btn_req = prio_encode(pressed);

  // A queued move always beats whatever is on the buttons.
  always_comb begin
    mv_req = btn_req;
    if (q_valid) begin
      mv_req.valid = 1'b1;
      mv_req.dir   = q_dir;
    end
  end

  hop_req_queue u_queue (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (q_clr),
    .i_pop      (q_pop),
    .i_push     (q_push),
    .i_push_dir (btn_req.dir),
    .o_valid    (q_valid),
    .o_dir      (q_dir)
  );

  // Signed working copies so bound checks cannot wrap below zero.
  assign cx      = $signed({1'b0, x_reg});
  assign cy      = $signed({1'b0, y_reg});
  assign drift_s = {{(13 - DRIFT_W){bus.i_drift[DRIFT_W-1]}}, bus.i_drift};

  // Hop target for the candidate move, judged against the current centre.
  always_comb begin
    tx = cx;
    ty = cy;
    case (mv_req.dir)
      UP:      ty = cy - HOP_DIS_S;
      DOWN:    ty = cy + HOP_DIS_S;
      LEFT:    tx = cx - HOP_DIS_S;
      RIGHT:   tx = cx + HOP_DIS_S;
      default: ;
    endcase
  end

  assign mv_legal = target_legal(tx, ty, H_WIDTH, H_HEIGHT, D_WIDTH, D_HEIGHT);

  // Horizontal hop step for the latched direction.
  always_comb begin
    sx = '0;
    case (dir_reg)
      LEFT:    sx = -STEP_S;
      RIGHT:   sx = STEP_S;
      default: ;
    endcase
  end

  function automatic logic [11:0] clamp_x(input logic signed [12:0] v);
    logic signed [12:0] c;
    c = v;
    if (v < X_MIN)      c = X_MIN;
    else if (v > X_MAX) c = X_MAX;
    return c[11:0];
  endfunction

  // Drift and hop step land together; the sum is clamped as one.
  assign x_idle = clamp_x(cx + drift_s);
  assign x_hop  = clamp_x(cx + sx + drift_s);
  assign y_hop  = (dir_reg == UP)   ? y_reg - 12'(HOP_STEP) :
                  (dir_reg == DOWN) ? y_reg + 12'(HOP_STEP) : y_reg;

  assign dist_inc = dist_reg + DIST_W'(HOP_STEP);

  always_comb begin
    state_next    = state_reg;
    x_next        = x_reg;
    y_next        = y_reg;
    dist_next     = dist_reg;
    dir_next      = dir_reg;
    cnt_next      = cnt_reg;
    lives_next    = lives_reg;
    hop_done_next = 1'b0;
    blocked_next  = 1'b0;
    q_push        = 1'b0;
    q_pop         = 1'b0;
    q_clr         = 1'b0;

    if (tick) begin
      // A kill outranks everything else on the tick, including the last
      // step of a hop; position is left exactly where it was.
      if ((state_reg == IDLE || state_reg == HOP) && bus.i_dead) begin
        state_next = DEAD;
        cnt_next   = CNT_W'(DEAD_FRAMES);
        q_clr      = 1'b1;
        lives_next = lives_reg - 3'd1;
      end else begin
        case (state_reg)
          IDLE: begin
            x_next = x_idle;
            if (mv_req.valid) begin
              q_pop = 1'b1;
              if (mv_legal) begin
                state_next = HOP;
                dir_next   = mv_req.dir;
                dist_next  = '0;
              end else begin
                blocked_next = 1'b1;
              end
            end
          end
          HOP: begin
            x_next    = x_hop;
            y_next    = y_hop;
            dist_next = dist_inc;
            q_push    = btn_req.valid;
            if (dist_inc == DIST_W'(HOP_DIS)) begin
              state_next    = IDLE;
              hop_done_next = 1'b1;
            end
          end
          DEAD: begin
            cnt_next = cnt_reg - CNT_W'(1);
            // Last frame of the sequence: respawn, then resume or end.
            if (cnt_reg == CNT_W'(1)) begin
              x_next     = 12'(IX);
              y_next     = 12'(IY);
              state_next = (lives_reg != 3'd0) ? IDLE : OVER;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg    <= IDLE;
      x_reg        <= 12'(IX);
      y_reg        <= 12'(IY);
      dist_reg     <= '0;
      dir_reg      <= UP;
      cnt_reg      <= '0;
      lives_reg    <= 3'(LIVES);
      hop_done_reg <= 1'b0;
      blocked_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      dist_reg     <= dist_next;
      dir_reg      <= dir_next;
      cnt_reg      <= cnt_next;
      lives_reg    <= lives_next;
      hop_done_reg <= hop_done_next;
      blocked_reg  <= blocked_next;
    end
  end

  assign bus.o_x1        = x_reg - 12'(H_WIDTH);
  assign bus.o_x2        = x_reg + 12'(H_WIDTH);
  assign bus.o_y1        = y_reg - 12'(H_HEIGHT);
  assign bus.o_y2        = y_reg + 12'(H_HEIGHT);
  assign bus.o_hopping   = (state_reg == HOP);
  assign bus.o_dying     = (state_reg == DEAD);
  assign bus.o_hop_done  = hop_done_reg;
  assign bus.o_blocked   = blocked_reg;
  assign bus.o_lives     = lives_reg;
  assign bus.o_game_over = (state_reg == OVER);

endmodule
